// File: rtl/pass_router_n.sv
// pass_router_n: password-gated loader that fills NCH output registers after a correct password,
// with lockout after MAX_TRIES consecutive wrong passwords.
module pass_router_n #(
    parameter int              DW          = 4,
    parameter int              NCH         = 2,
    parameter logic [DW-1:0]   PASS        = 4'b1010,
    parameter int              MAX_TRIES   = 3,
    parameter int              LOCK_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DW-1:0]     din,
    input  logic              confirm,
    output logic [NCH*DW-1:0] dout,
    output logic [NCH-1:0]    valid,
    output logic              locked,
    output logic              busy
);
    localparam int PW = NCH > 1 ? $clog2(NCH) : 1;
    localparam int TW = LOCK_CYCLES > 1 ? $clog2(LOCK_CYCLES) : 1;
    localparam int FW = $clog2(MAX_TRIES + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    localparam logic [1:0] LOCK = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [FW-1:0]     fail_q, fail_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [NCH*DW-1:0] dout_q, dout_d;
    logic [NCH-1:0]    valid_q, valid_d;
    logic              conf_q, locked_q, busy_q;
    logic              ev;

    assign ev = confirm && !conf_q;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        fail_d  = fail_q;
        timer_d = timer_q;
        dout_d  = dout_q;
        valid_d = valid_q;
        case (state_q)
            IDLE: if (ev) begin
                if (din == PASS) begin
                    state_d = LOAD;
                    ptr_d   = '0;
                    fail_d  = '0;
                    valid_d = '0;
                end else if (fail_q + 1'b1 == FW'(MAX_TRIES)) begin
                    state_d = LOCK;
                    timer_d = TW'(LOCK_CYCLES - 1);
                    fail_d  = '0;
                end else begin
                    fail_d = fail_q + 1'b1;
                end
            end
            LOAD: if (ev) begin
                dout_d[ptr_q*DW +: DW] = din;
                valid_d[ptr_q]         = 1'b1;
                state_d = ptr_q == PW'(NCH - 1) ? DONE : LOAD;
                ptr_d   = ptr_q == PW'(NCH - 1) ? '0 : ptr_q + 1'b1;
            end
            DONE: if (ev && din == PASS) begin
                state_d = LOAD;
                ptr_d   = '0;
                valid_d = '0;
            end
            default: begin
                // confirm events are ignored while the lockout timer runs down
                state_d = timer_q == '0 ? IDLE : LOCK;
                timer_d = timer_q == '0 ? '0 : timer_q - 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            fail_q   <= '0;
            timer_q  <= '0;
            dout_q   <= '0;
            valid_q  <= '0;
            conf_q   <= 1'b0;
            locked_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            fail_q   <= fail_d;
            timer_q  <= timer_d;
            dout_q   <= dout_d;
            valid_q  <= valid_d;
            conf_q   <= confirm;
            locked_q <= state_d == LOCK;
            busy_q   <= state_d == LOAD;
        end
    end

    assign dout   = dout_q;
    assign valid  = valid_q;
    assign locked = locked_q;
    assign busy   = busy_q;
endmodule
